// File: rtl/smbus_echo_checker.sv
// Originator-side SMBus echo tracker: waits for the remote echo of each sent event,
// requests retransmits on timeout and strips echo-class events from the relay's RX stream.
module smbus_echo_checker #(
    parameter int unsigned TIMEOUT_FRAMES = 4,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       echo_en,
    input  logic       frame_tick,
    input  logic [3:0] tx_event_i,
    input  logic [3:0] rx_event_i,
    output logic [3:0] rx_event_o,
    output logic       busy_o,
    output logic       echo_ok_o,
    output logic       echo_err_o,
    output logic       retx_req_o,
    output logic [3:0] retx_event_o,
    output logic [7:0] err_cnt_o
);

    // smbus_event_t encodings
    localparam logic [3:0] EvIdle        = 4'd0;
    localparam logic [3:0] EvStart       = 4'd1;
    localparam logic [3:0] EvStop        = 4'd2;
    localparam logic [3:0] EvData0       = 4'd3;
    localparam logic [3:0] EvData1       = 4'd4;
    localparam logic [3:0] EvBitRcv      = 4'd5;
    localparam logic [3:0] EvStartEcho   = 4'd8;
    localparam logic [3:0] EvStopEcho    = 4'd9;
    localparam logic [3:0] EvData0Echo   = 4'd10;
    localparam logic [3:0] EvData1Echo   = 4'd11;
    localparam logic [3:0] EvDataRcvEcho = 4'd12;

    localparam logic [3:0] TimeoutLast = 4'(TIMEOUT_FRAMES - 1);
    localparam logic [2:0] RetryMax    = 3'(MAX_RETRY);

    typedef enum logic [1:0] {StIdle, StWait, StRetx} state_t;

    // Expected echo for a tracked event; idle means the event is not tracked.
    function automatic logic [3:0] echo_of(input logic [3:0] ev);
        case (ev)
            EvStart:  echo_of = EvStartEcho;
            EvData0:  echo_of = EvData0Echo;
            EvData1:  echo_of = EvData1Echo;
            EvBitRcv: echo_of = EvDataRcvEcho;
            EvStop:   echo_of = EvStopEcho;
            default:  echo_of = EvIdle;
        endcase
    endfunction

    function automatic logic is_echo(input logic [3:0] ev);
        is_echo = (ev == EvStartEcho) || (ev == EvStopEcho) || (ev == EvData0Echo) ||
                  (ev == EvData1Echo) || (ev == EvDataRcvEcho);
    endfunction

    state_t     state_q;
    logic [3:0] frame_q;
    logic [2:0] retry_q;
    logic [3:0] exp_q;
    logic [3:0] tx_prev_q;
    logic [3:0] rx_prev_q;

    logic tx_accept;
    logic echo_hit;
    logic timeout;

    assign tx_accept = echo_en && (echo_of(tx_event_i) != EvIdle) && (tx_prev_q == EvIdle);
    assign echo_hit  = (rx_event_i != rx_prev_q) && (rx_event_i == exp_q);
    assign timeout   = frame_tick && (frame_q == TimeoutLast);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            frame_q      <= '0;
            retry_q      <= '0;
            exp_q        <= EvIdle;
            tx_prev_q    <= EvIdle;
            rx_prev_q    <= EvIdle;
            rx_event_o   <= EvIdle;
            busy_o       <= 1'b0;
            echo_ok_o    <= 1'b0;
            echo_err_o   <= 1'b0;
            retx_req_o   <= 1'b0;
            retx_event_o <= EvIdle;
            err_cnt_o    <= '0;
        end else begin
            tx_prev_q  <= tx_event_i;
            rx_prev_q  <= rx_event_i;
            rx_event_o <= (echo_en && is_echo(rx_event_i)) ? EvIdle : rx_event_i;
            echo_ok_o  <= 1'b0;
            echo_err_o <= 1'b0;
            retx_req_o <= 1'b0;

            if (!echo_en) begin
                state_q <= StIdle;
                frame_q <= '0;
                retry_q <= '0;
                busy_o  <= 1'b0;
            end else if (tx_accept) begin
                // A new event while one is outstanding overruns it; any pending retx is dropped.
                if (state_q != StIdle) begin
                    echo_err_o <= 1'b1;
                    if (err_cnt_o != 8'hff) err_cnt_o <= err_cnt_o + 8'd1;
                end
                state_q      <= StWait;
                busy_o       <= 1'b1;
                retx_event_o <= tx_event_i;
                exp_q        <= echo_of(tx_event_i);
                frame_q      <= '0;
                retry_q      <= '0;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StWait: begin
                        if (echo_hit) begin
                            echo_ok_o <= 1'b1;
                            busy_o    <= 1'b0;
                            state_q   <= StIdle;
                        end else if (timeout) begin
                            frame_q <= '0;
                            if (retry_q < RetryMax) begin
                                state_q <= StRetx;
                            end else begin
                                echo_err_o <= 1'b1;
                                if (err_cnt_o != 8'hff) err_cnt_o <= err_cnt_o + 8'd1;
                                busy_o  <= 1'b0;
                                state_q <= StIdle;
                            end
                        end else if (frame_tick) begin
                            frame_q <= frame_q + 4'd1;
                        end
                    end
                    StRetx: begin
                        retx_req_o <= 1'b1;
                        retry_q    <= retry_q + 3'd1;
                        frame_q    <= '0;
                        state_q    <= StWait;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
